serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL expose parameter: WIDTH, 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL expose ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL expose ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL expose ports: start  input  1  request to begin one addition.
REQ-005 SHALL expose ports: a  input  WIDTH  operand A; b  input  WIDTH  operand B; cin  input  1  carry-in; all sampled only on an accepted start.
REQ-006 SHALL expose ports: busy  output  1  high while bits are being processed.
REQ-007 SHALL expose ports: done  output  1  one-cycle pulse marking a new valid result.
REQ-008 SHALL expose ports: sum  output  WIDTH  result; cout  output  1  carry-out of the MSB.
REQ-009 SHALL expose ports: ovf  output  1  two's-complement overflow; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 SHALL accept start only when busy=0, in IDLE or DONE; on acceptance load a and b into shift registers, load the carry register from cin, clear the bit counter, and enter RUN.
REQ-012 SHALL, in each RUN cycle, add the LSB of each operand shift register plus the carry register, shift the sum bit into the MSB of a result shift register, update the carry register, shift both operands right, and increment the counter.
REQ-013 SHALL leave RUN after exactly WIDTH cycles, enter DONE, copy the result shift register to sum and the final carry to cout, and assert done for exactly that one cycle.
REQ-014 SHALL give fixed latency: start sampled high at edge T gives done high in the cycle after edge T+WIDTH+1.
REQ-015 SHALL hold sum, cout and ovf stable from DONE until the next DONE; these outputs SHALL NOT change during RUN.
REQ-016 SHALL drive busy=1 exactly in RUN; start while busy=1 SHALL be ignored, with no effect on operands or counter.
REQ-017 SHALL return DONE to IDLE on the next edge when start=0; when start=1 in DONE, SHALL go straight to RUN with no idle bubble.
REQ-018 SHALL produce sum = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of a+b+cin.
REQ-019 SHALL size the counter at $clog2(WIDTH+1) bits, so WIDTH=2^k needs no special case.

Reset
REQ-020 SHALL, while rst_n=0, immediately force: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, counter 0, all shift and carry registers 0.
REQ-021 SHALL abort any addition in progress when reset asserts mid-RUN; no done pulse is emitted for the aborted addition, and the first accepted start after release behaves as from power-up.

Configuration
REQ-022 SHALL, with macro SERIAL_ADDER_OVF_EN defined, provide port ovf = carry into the MSB XOR carry out of the MSB, captured with sum in DONE and reset to 0.
REQ-023 SHALL, without SERIAL_ADDER_OVF_EN, omit the ovf port and its register; all other behaviour stays identical.

Structure
REQ-024 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-025 SHALL implement the per-bit add as a single combinational sub-module fa_cell (ports a, b, ci, s, co), instantiated once.

Verification
REQ-026 SHALL cover, with WIDTH=8: a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, done exactly 9 cycles after start, busy high for 8 cycles.
REQ-027 SHALL cover: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-028 SHALL cover: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; ovf=1 when SERIAL_ADDER_OVF_EN is defined.
REQ-029 SHALL cover: start re-pulsed with a=0x55 at cycle 3 of RUN -> ignored; the original result is produced on schedule; start held high in DONE launches the next addition with no idle cycle.
REQ-030 SHALL cover: rst_n pulsed low at cycle 4 of RUN -> all outputs 0 at once, no done pulse; next start with a=0x01, b=0x02 -> sum=0x03.
REQ-031 SHALL cover: WIDTH=2, all 32 combinations of a, b and cin checked against a+b+cin.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder used as the serial adder's per-bit datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule : fa_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, fixed WIDTH+1 cycle latency.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s_c;
    logic             bit_co_c;
    logic             last_c;
    logic             accept_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             c_msb;
`endif

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s_c),
        .co (bit_co_c)
    );

    always_comb begin
        last_c   = (cnt == CW'(WIDTH - 1));
        accept_c = start && ((state == ST_IDLE) || (state == ST_DONE));
    end

    // DONE is a one-cycle publish state; the done pulse follows it, giving WIDTH+1 latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
            c_msb  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: ;
                ST_RUN: begin
                    res_sr <= {bit_s_c, res_sr[WIDTH-1:1]};
                    carry  <= bit_co_c;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_c) begin
`ifdef SERIAL_ADDER_OVF_EN
                        c_msb <= carry;
`endif
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    sum  <= res_sr;
                    cout <= carry;
                    done <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf  <= c_msb ^ carry;
`endif
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Acceptance overrides the DONE->IDLE move so back-to-back adds have no bubble.
            if (accept_c) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                cnt   <= '0;
                state <= ST_RUN;
                busy  <= 1'b1;
            end
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench: 8-bit vector table, multi-cycle corner sequences, 2-bit exhaustive sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_sum8 = 8'h00;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit add from IDLE; checks result, latency, busy length and sum stability in RUN.
    task automatic run_add8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                            input logic [7:0] es, input logic eco, input logic eov,
                            input string name);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        logic [7:0] mid_sum = 8'h00;
        a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            step();
            if (c == 0) begin
                start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
            end
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 4) mid_sum = sum8;
            if (c == 9) begin
                chk({name, "_sum"}, 64'(sum8), 64'(es));
                chk({name, "_cout"}, 64'(cout8), 64'(eco));
`ifdef SERIAL_ADDER_OVF_EN
                chk({name, "_ovf"}, 64'(ovf8), 64'(eov));
`endif
            end
        end
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
        chk({name, "_done_cycle"}, 64'(done_cyc), 64'd9);
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_sum_stable_in_run"}, 64'(mid_sum), 64'(prev_sum8));
        prev_sum8 = es;
    endtask

    task automatic run_add2(input logic [1:0] va, input logic [1:0] vb, input logic vc);
        logic [2:0] full;
        logic       eov;
        int done_cyc = -1;
        full = 3'(va) + 3'(vb) + 3'(vc);
        eov  = (va[1] == vb[1]) && (full[1] != va[1]);
        a2 = va; b2 = vb; cin2 = vc; start2 = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            step();
            if (c == 0) begin
                start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
            end
            if (done2 && done_cyc < 0) done_cyc = c;
        end
        chk($sformatf("w2_%0d_%0d_%0d_sum", va, vb, vc), 64'(sum2), 64'(full[1:0]));
        chk($sformatf("w2_%0d_%0d_%0d_cout", va, vb, vc), 64'(cout2), 64'(full[2]));
        chk($sformatf("w2_%0d_%0d_%0d_done_cycle", va, vb, vc), 64'(done_cyc), 64'd3);
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("w2_%0d_%0d_%0d_ovf", va, vb, vc), 64'(ovf2), 64'(eov));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        int busy_seen;

        vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h64, b: 8'h64, cin: 1'b0, sum: 8'hC8, cout: 1'b0, ovf: 1'b1};
        vecs[7] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
        #23;
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_sum", 64'(sum8), 64'd0);
        chk("reset_cout", 64'(cout8), 64'd0);
        chk("reset_ovf", 64'(ovf8), 64'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i])
            run_add8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                     $sformatf("vec%0d", i));

        // Start re-pulsed mid-RUN is ignored; start held in DONE chains the next add with no bubble.
        done_cnt = 0;
        a8 = 8'h21; b8 = 8'h13; cin8 = 1'b0; start8 = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            step();
            if (done8) done_cnt++;
            if (c == 0 || c == 3 || c == 9) begin
                start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
            end
            if (c == 2) begin
                start8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
            end
            if (c == 5) chk("rerun_busy_mid", 64'(busy8), 64'd1);
            if (c == 8) begin
                start8 = 1'b1; a8 = 8'h40; b8 = 8'h02; cin8 = 1'b1;
            end
            if (c == 9) begin
                chk("rerun_first_done", 64'(done8), 64'd1);
                chk("rerun_first_sum", 64'(sum8), 64'h34);
                chk("rerun_first_cout", 64'(cout8), 64'd0);
                chk("chain_no_bubble_busy", 64'(busy8), 64'd1);
            end
            if (c == 13) chk("chain_sum_stable", 64'(sum8), 64'h34);
            if (c == 17) chk("chain_busy_end", 64'(busy8), 64'd0);
            if (c == 18) begin
                chk("chain_second_done", 64'(done8), 64'd1);
                chk("chain_second_sum", 64'(sum8), 64'h43);
                chk("chain_second_cout", 64'(cout8), 64'd0);
            end
        end
        chk("chain_done_pulses", 64'(done_cnt), 64'd2);

        // Reset in the 4th RUN cycle clears outputs at once and suppresses the done pulse.
        a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_done", 64'(done8), 64'd0);
        chk("abort_sum", 64'(sum8), 64'd0);
        chk("abort_cout", 64'(cout8), 64'd0);
        chk("abort_ovf", 64'(ovf8), 64'd0);
        step(); step();
        #3 rst_n = 1'b1;
        done_cnt = 0;
        busy_seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done8) done_cnt++;
            if (busy8) busy_seen++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_no_busy", 64'(busy_seen), 64'd0);
        prev_sum8 = 8'h00;
        run_add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "post_reset");

        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_add2(2'(ia), 2'(ib), 1'(ic));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
